// File: rtl/bip_dbg_pkg.sv
// Shared definitions for the BIP debug sequencer.
// - state_t         : sequencer FSM states
// - START_CMD_DEF   : default command byte that launches a run
// - FRAME_LEN/IDX_W : length of the PC/ACC/count frame and its byte-index width
package bip_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_RUN,
    S_WAIT_TX,
    S_PUSH
  } state_t;

  localparam logic [7:0] START_CMD_DEF = 8'h53;
  localparam int         FRAME_LEN     = 6;
  localparam int         IDX_W         = $clog2(FRAME_LEN);

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : synchronous clear (wins over enable)
//   en_i       : count enable; holds at all-ones once reached
//   cnt_o      : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bip_debug_sequencer.sv
// Debug-side sequencer for the BIP core: accepts a start byte from the UART RX
// FIFO, runs the core until halt while counting cycles, then sends a 6-byte
// frame {pc16, acc16, count16} (MSB first) into the UART TX FIFO.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   rx_data, rx_empty : head of the FWFT RX FIFO;  rd_uart pops it
//   tx_full           : TX FIFO full;  wr_uart pushes tx_data
//   halt, pc, acc     : status from the core;  start_bip enables it
//   busy              : high whenever the sequencer is not idle
module bip_debug_sequencer
  import bip_dbg_pkg::*;
#(
  parameter int         AB        = 11,
  parameter int         DB        = 16,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] START_CMD = START_CMD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_empty,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic          wr_uart,
  output logic [7:0]    tx_data,
  input  logic          halt,
  input  logic [AB-1:0] pc,
  input  logic [DB-1:0] acc,
  output logic          start_bip,
  output logic          busy
);

  state_t           state_q, state_d;
  logic             is_start_q, is_start_d;
  idx_t             idx_q, idx_d;
  logic [AB-1:0]    pc_q, pc_d;
  logic [DB-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_snap_q, cnt_snap_d;
  logic [CNT_W-1:0] cnt;

  // Counter is cleared while popping the start byte, so the first RUN cycle
  // sees 0; the halt cycle itself is never counted.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == S_POP),
    .en_i  ((state_q == S_RUN) && !halt),
    .cnt_o (cnt)
  );

  always_comb begin
    state_d    = state_q;
    is_start_d = is_start_q;
    idx_d      = idx_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    cnt_snap_d = cnt_snap_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          is_start_d = (rx_data == START_CMD);
          state_d    = S_POP;
        end
      end
      S_POP: state_d = is_start_q ? S_RUN : S_IDLE;
      S_RUN: begin
        if (halt) begin
          pc_d       = pc;
          acc_d      = acc;
          cnt_snap_d = cnt;
          idx_d      = '0;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: if (!tx_full) state_d = S_PUSH;
      S_PUSH: begin
        if (idx_q == idx_t'(FRAME_LEN - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WAIT_TX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_start_q <= 1'b0;
      idx_q      <= '0;
      pc_q       <= '0;
      acc_q      <= '0;
      cnt_snap_q <= '0;
    end else begin
      state_q    <= state_d;
      is_start_q <= is_start_d;
      idx_q      <= idx_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      cnt_snap_q <= cnt_snap_d;
    end
  end

  // Frame fields widened to the 16-bit wire format.
  logic [15:0] pc16, acc16, cnt16;
  assign pc16  = 16'(pc_q);
  assign acc16 = 16'(acc_q);
  assign cnt16 = 16'(cnt_snap_q);

  // Byte mux is driven from registers only, so tx_data is stable in PUSH and
  // holds a defined value in every state.
  always_comb begin
    tx_data = 8'h00;
    case (idx_q)
      idx_t'(0): tx_data = pc16[15:8];
      idx_t'(1): tx_data = pc16[7:0];
      idx_t'(2): tx_data = acc16[15:8];
      idx_t'(3): tx_data = acc16[7:0];
      idx_t'(4): tx_data = cnt16[15:8];
      idx_t'(5): tx_data = cnt16[7:0];
      default:   tx_data = 8'h00;
    endcase
  end

  assign rd_uart   = (state_q == S_POP);
  assign start_bip = (state_q == S_RUN);
  assign wr_uart   = (state_q == S_PUSH);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bip_debug_sequencer.sv
module tb_bip_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        tx_full;
  logic        halt;
  logic [10:0] pc;
  logic [15:0] acc;

  logic       rd_uart, wr_uart, start_bip, busy;
  logic [7:0] tx_data;
  logic       rd4, wr4, start4, busy4;
  logic [7:0] tx4;

  int checks = 0;
  int errors = 0;

  logic [7:0] q16[$];
  logic [7:0] q4[$];

  always #5 clk = ~clk;

  bip_debug_sequencer #(.AB(11), .DB(16), .CNT_W(16), .START_CMD(8'h53)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .tx_data(tx_data),
    .halt(halt), .pc(pc), .acc(acc), .start_bip(start_bip), .busy(busy)
  );

  bip_debug_sequencer #(.AB(11), .DB(16), .CNT_W(4), .START_CMD(8'h53)) dut4 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_uart(rd4), .tx_full(tx_full), .wr_uart(wr4), .tx_data(tx4),
    .halt(halt), .pc(pc), .acc(acc), .start_bip(start4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference frame: PC/ACC sampled on the halt cycle, count = RUN cycles
  // before halt, clipped to the counter's maximum.
  task automatic push_expected(input logic [10:0] p, input logic [15:0] a, input int halt_at);
    int          n;
    logic [15:0] p16, c16, c4;
    n   = halt_at - 1;
    p16 = {5'd0, p};
    c16 = (n > 65535) ? 16'hFFFF : 16'(n);
    c4  = (n > 15) ? 16'd15 : 16'(n);
    q16.push_back(p16[15:8]); q16.push_back(p16[7:0]);
    q16.push_back(a[15:8]);   q16.push_back(a[7:0]);
    q16.push_back(c16[15:8]); q16.push_back(c16[7:0]);
    q4.push_back(p16[15:8]);  q4.push_back(p16[7:0]);
    q4.push_back(a[15:8]);    q4.push_back(a[7:0]);
    q4.push_back(c4[15:8]);   q4.push_back(c4[7:0]);
  endtask

  // One command byte through the whole sequence. Called at a negedge with the
  // DUT idle. reset_at>0 aborts the run with a reset pulse in that RUN cycle.
  task automatic do_run(input logic [7:0] b, input int halt_at, input bit rand_core,
                        input bit stall, input int reset_at);
    int k, pushes, cyc;
    bit done, stalled;
    rx_data  = b;
    rx_empty = 1'b0;
    @(negedge clk);
    check("pop_strobe", {31'd0, rd_uart}, 1);
    check("pop_start_bip", {31'd0, start_bip}, 0);
    check("pop_busy", {31'd0, busy}, 1);
    rx_empty = 1'b1;
    rx_data  = 8'($urandom);
    if (b != 8'h53) begin
      @(negedge clk);
      check("discard_idle", {31'd0, busy}, 0);
      check("discard_no_run", {31'd0, start_bip}, 0);
      $display("RX byte %02h discarded", b);
      return;
    end
    k = 0; done = 0;
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
      check("run_start_bip", {31'd0, start_bip}, 1);
      if (rand_core) begin
        pc  = 11'($urandom);
        acc = 16'($urandom);
      end
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_start_bip", {31'd0, start_bip}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        $display("RUN aborted by reset in cycle %0d", k);
        return;
      end else if (k == halt_at) begin
        halt = 1'b1;
        push_expected(pc, acc, halt_at);
        done = 1;
      end
    end
    if (!done) begin
      check("run_timeout", 1, 0);
      return;
    end
    @(negedge clk);
    halt = 1'b0;
    check("halt_drop", {31'd0, start_bip}, 0);
    if (rand_core) begin
      pc  = 11'($urandom);
      acc = 16'($urandom);
    end
    pushes = 0; cyc = 0; stalled = 0;
    while (pushes < 6 && cyc < 2000) begin
      if (stall && pushes == 2 && !stalled) begin
        stalled = 1;
        tx_full = 1'b1;
        repeat (20) begin
          @(negedge clk);
          check("stall_no_push", {31'd0, wr_uart}, 0);
        end
        tx_full = 1'b0;
      end else if (!stall) begin
        tx_full = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      cyc++;
      if (wr_uart) pushes++;
    end
    tx_full = 1'b0;
    check("frame_len", pushes, 6);
    @(negedge clk);
    check("frame_end_idle", {31'd0, busy}, 0);
    $display("RUN halt_at=%0d frame done in %0d cycles", halt_at, cyc);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_empty = 1'b1; tx_full = 1'b0;
    halt = 1'b0; pc = '0; acc = '0;
    fork
      begin : monitor
        bit prev_strobe = 0;
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (!reset) begin
            if (rd_uart || wr_uart) check("strobe_gap", {31'd0, prev_strobe}, 0);
            if (wr_uart) begin
              if (q16.size() == 0) check("unexpected_push16", {24'd0, tx_data}, 32'hFFFF_FFFF);
              else begin
                e = q16.pop_front();
                check("tx_byte16", {24'd0, tx_data}, {24'd0, e});
                $display("TX16 %02h (exp %02h)", tx_data, e);
              end
            end
            if (wr4) begin
              if (q4.size() == 0) check("unexpected_push4", {24'd0, tx4}, 32'hFFFF_FFFF);
              else begin
                e = q4.pop_front();
                check("tx_byte4", {24'd0, tx4}, {24'd0, e});
                $display("TX4  %02h (exp %02h)", tx4, e);
              end
            end
          end
          prev_strobe = rd_uart || wr_uart;
        end
      end
      begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_rd", {31'd0, rd_uart}, 0);
        check("rst_wr", {31'd0, wr_uart}, 0);
        check("rst_start", {31'd0, start_bip}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 0);
        check("post_rst_tx_data", {24'd0, tx_data}, 0);

        pc = 11'h00A; acc = 16'h1234;
        do_run(8'h53, 11, 0, 0, 0);
        do_run(8'h41, 0, 0, 0, 0);
        pc = 11'h7FF; acc = 16'hFFFF;
        do_run(8'h53, 1, 0, 0, 0);
        pc = 11'h00A; acc = 16'h1234;
        do_run(8'h53, 11, 0, 1, 0);
        pc = 11'h123; acc = 16'hBEEF;
        do_run(8'h53, 40, 0, 0, 0);
        do_run(8'h53, 0, 1, 0, 5);
        pc = 11'h00A; acc = 16'h1234;
        do_run(8'h53, 11, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
          logic [7:0] b;
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h53;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_run(b, int'($urandom_range(1, 60)), 1, 0, 0);
        end

        repeat (4) @(negedge clk);
        check("queue16_empty", q16.size(), 0);
        check("queue4_empty", q4.size(), 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
